// File: rtl/multi_dataflow_sobel_mdc_job_tracker.sv
// Job sequencer for the Sobel MDC HWPE: accepts a start pulse and an output-beat limit,
// waits for the source/sink streamers, issues one-cycle start requests, counts out_pel
// handshakes up to the limit and waits for the sink to flush before pulsing done_o.
//
// Optional watchdog: define MULTI_DATAFLOW_SOBEL_MDC_JOB_TRACKER_WDOG_EN to compile in a
// WDOG_W-bit idle counter that aborts a stalled job (err_o[1]) with a normal done_o pulse.
// Without the macro there is no watchdog and err_o[1] stays 0.

module multi_dataflow_sobel_mdc_job_tracker #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned N_SRC     = 2,
  parameter int unsigned WDOG_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] cnt_limit_i,
  input  logic [N_SRC-1:0]     src_ready_i,
  input  logic                 sink_ready_i,
  output logic [N_SRC-1:0]     src_req_o,
  output logic                 sink_req_o,
  input  logic                 out_valid_i,
  input  logic                 out_ready_i,
  input  logic                 sink_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] beat_cnt_o,
  output logic [1:0]           err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StIssue,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e               state;
  logic [CNT_WIDTH-1:0] limit;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic [1:0]           err;
  logic                 sink_done_flag;
  logic [N_SRC-1:0]     src_req;
  logic                 sink_req;
  logic                 busy;
  logic                 done;

  logic                 beat;
  logic                 all_ready;
  logic [CNT_WIDTH-1:0] beat_cnt_nxt;

  assign beat         = out_valid_i && out_ready_i;
  assign all_ready    = (&src_ready_i) && sink_ready_i;
  assign beat_cnt_nxt = beat_cnt + CNT_WIDTH'(1);

`ifdef MULTI_DATAFLOW_SOBEL_MDC_JOB_TRACKER_WDOG_EN
  logic [WDOG_W-1:0] wdog;
`else
  // Watchdog width only matters when the watchdog is compiled in.
  logic [WDOG_W-1:0] unused_wdog_w;
  assign unused_wdog_w = '0;
`endif

  // Job FSM with registered request/status outputs; reset and clear zero everything.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state          <= StIdle;
      limit          <= '0;
      beat_cnt       <= '0;
      err            <= '0;
      sink_done_flag <= 1'b0;
      src_req        <= '0;
      sink_req       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef MULTI_DATAFLOW_SOBEL_MDC_JOB_TRACKER_WDOG_EN
      wdog           <= '0;
`endif
    end else begin
      // Pulse outputs default low; only the transitions below raise them for one cycle.
      src_req  <= '0;
      sink_req <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start_i) begin
            limit          <= cnt_limit_i;
            beat_cnt       <= '0;
            sink_done_flag <= 1'b0;
            busy           <= 1'b1;
            if (cnt_limit_i == '0) begin
              // Nothing to stream: report the bad limit and complete immediately.
              err   <= 2'b01;
              done  <= 1'b1;
              state <= StDone;
            end else begin
              err   <= 2'b00;
              state <= StWaitRdy;
            end
          end
        end
        StWaitRdy: begin
          if (all_ready) begin
            src_req  <= '1;
            sink_req <= 1'b1;
            state    <= StIssue;
          end
        end
        StIssue: begin
          state <= StRun;
`ifdef MULTI_DATAFLOW_SOBEL_MDC_JOB_TRACKER_WDOG_EN
          wdog  <= '0;
`endif
        end
        StRun: begin
          // The sink may finish together with (or, in theory, before) the last beat.
          if (sink_done_i) sink_done_flag <= 1'b1;
          if (beat) begin
            beat_cnt <= beat_cnt_nxt;
            if (beat_cnt_nxt == limit) state <= StDrain;
          end
`ifdef MULTI_DATAFLOW_SOBEL_MDC_JOB_TRACKER_WDOG_EN
          if (beat || sink_done_i) begin
            wdog <= '0;
          end else if (&wdog) begin
            err[1] <= 1'b1;
            done   <= 1'b1;
            state  <= StDone;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
`endif
        end
        StDrain: begin
          if (sink_done_i || sink_done_flag) begin
            done  <= 1'b1;
            state <= StDone;
          end
`ifdef MULTI_DATAFLOW_SOBEL_MDC_JOB_TRACKER_WDOG_EN
          else if (&wdog) begin
            err[1] <= 1'b1;
            done   <= 1'b1;
            state  <= StDone;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
`endif
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign src_req_o  = src_req;
  assign sink_req_o = sink_req;
  assign busy_o     = busy;
  assign done_o     = done;
  assign beat_cnt_o = beat_cnt;
  assign err_o      = err;

endmodule

// File: tb/tb_multi_dataflow_sobel_mdc_job_tracker.sv
// Self-checking bench for multi_dataflow_sobel_mdc_job_tracker. Cycle n is the interval
// starting 1 time unit after the n-th rising edge; inputs set there are sampled at edge n+1.
module tb_multi_dataflow_sobel_mdc_job_tracker;
  localparam int CW = 32;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          rst_n, clear, start, sink_ready, out_valid, out_ready, sink_done;
  logic [CW-1:0] cnt_limit;
  logic [NS-1:0] src_ready;
  logic [NS-1:0] src_req;
  logic          sink_req, busy, done;
  logic [CW-1:0] beat_cnt;
  logic [1:0]    err;
  logic [NS-1:0] all_src;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int req_seen = 0;

  multi_dataflow_sobel_mdc_job_tracker #(
    .CNT_WIDTH(CW),
    .N_SRC    (NS),
    .WDOG_W   (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .start_i     (start),
    .cnt_limit_i (cnt_limit),
    .src_ready_i (src_ready),
    .sink_ready_i(sink_ready),
    .src_req_o   (src_req),
    .sink_req_o  (sink_req),
    .out_valid_i (out_valid),
    .out_ready_i (out_ready),
    .sink_done_i (sink_done),
    .busy_o      (busy),
    .done_o      (done),
    .beat_cnt_o  (beat_cnt),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Advance one cycle and tally observed pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (done) done_seen++;
    if (src_req != '0) req_seen++;
  endtask

  // Stimulus only: pulse start for one cycle; returns in cycle 1 of the job.
  task automatic start_job(input int lim);
    cnt_limit = CW'(lim);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Stimulus only: n handshakes with random gaps (at most 2 idle cycles in a row).
  task automatic send_beats(input int n);
    int sent = 0;
    int gap = 0;
    while (sent < n) begin
      out_valid = ($urandom_range(0, 1) == 1) || (gap >= 2);
      out_ready = ($urandom_range(0, 1) == 1) || (gap >= 2);
      if (out_valid && out_ready) begin
        sent++;
        gap = 0;
      end else begin
        gap++;
      end
      tick();
    end
    out_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 0; start = 0; cnt_limit = '0; src_ready = '1; sink_ready = 1;
    out_valid = 0; out_ready = 0; sink_done = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({src_req, sink_req, busy, done} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0", {src_req, sink_req, busy, done});
    end
    checks++;
    if (beat_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", beat_cnt); end
    checks++;
    if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
  endtask

  task automatic test_nominal();
    int d0 = done_seen;
    int r0 = req_seen;
    src_ready = '1; sink_ready = 1'b1;
    start_job(16);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy: got %b expected 1", busy); end
    tick();  // cycle 2
    checks++;
    if (src_req !== all_src || sink_req !== 1'b1) begin
      errors++; $display("FAIL nom_req: got %b/%b expected %b/1", src_req, sink_req, all_src);
    end
    tick();  // cycle 3, RUN
    checks++;
    if ({src_req, sink_req} !== '0) begin
      errors++; $display("FAIL nom_req_pulse: got %b expected 0", {src_req, sink_req});
    end
    send_beats(16);  // now cycle t+1
    checks++;
    if (beat_cnt !== CW'(16) || done !== 1'b0) begin
      errors++; $display("FAIL nom_cnt: got cnt %0d done %b expected 16 0", beat_cnt, done);
    end
    tick(); tick();
    sink_done = 1'b1;  // 3 cycles after the last beat
    tick();
    sink_done = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 2'b00 || beat_cnt !== CW'(16)) begin
      errors++; $display("FAIL nom_done: got done %b err %b cnt %0d expected 1 00 16",
                         done, err, beat_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL nom_idle: got done %b busy %b expected 0 0", done, busy);
    end
    checks++;
    if (done_seen - d0 != 1 || req_seen - r0 != 1) begin
      errors++; $display("FAIL nom_pulses: got done %0d req %0d expected 1 1",
                         done_seen - d0, req_seen - r0);
    end
  endtask

  task automatic test_ready_gating();
    src_ready = '1; sink_ready = 1'b0; out_valid = 1'b1; out_ready = 1'b1;
    start_job(8);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({src_req, sink_req} !== '0 || beat_cnt !== '0) begin
        errors++; $display("FAIL gate_wait%0d: got req %b cnt %0d expected 0 0",
                           i, {src_req, sink_req}, beat_cnt);
      end
      tick();
    end
    sink_ready = 1'b1;
    tick();
    checks++;
    if (src_req !== all_src || sink_req !== 1'b1) begin
      errors++; $display("FAIL gate_req: got %b/%b expected %b/1", src_req, sink_req, all_src);
    end
    tick();  // first RUN cycle; the ISSUE-cycle beat is not counted
    checks++;
    if (beat_cnt !== '0) begin errors++; $display("FAIL gate_issue_beat: got %0d expected 0", beat_cnt); end
    repeat (10) tick();  // 8 counted beats, then 2 more in DRAIN
    out_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (beat_cnt !== CW'(8)) begin errors++; $display("FAIL gate_cnt: got %0d expected 8", beat_cnt); end
    sink_done = 1'b1;
    tick();
    sink_done = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL gate_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_early_sink_done();
    src_ready = '1; sink_ready = 1'b1;
    start_job(4);
    tick(); tick();
    send_beats(3);
    out_valid = 1'b1; out_ready = 1'b1; sink_done = 1'b1;  // 4th beat with sink_done
    tick();
    sink_done = 1'b0;  // beats keep coming during DRAIN
    checks++;
    if (done !== 1'b0 || beat_cnt !== CW'(4)) begin
      errors++; $display("FAIL early_drain: got done %b cnt %0d expected 0 4", done, beat_cnt);
    end
    tick();
    out_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || beat_cnt !== CW'(4)) begin
      errors++; $display("FAIL early_done: got done %b cnt %0d expected 1 4", done, beat_cnt);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || beat_cnt !== CW'(4)) begin
      errors++; $display("FAIL early_hold: got busy %b cnt %0d expected 0 4", busy, beat_cnt);
    end
  endtask

  task automatic test_zero_limit();
    int r0 = req_seen;
    start_job(0);
    checks++;
    if (done !== 1'b1 || err !== 2'b01 || busy !== 1'b1) begin
      errors++; $display("FAIL zero_done: got done %b err %b busy %b expected 1 01 1", done, err, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 2'b01) begin
      errors++; $display("FAIL zero_after: got done %b busy %b err %b expected 0 0 01", done, busy, err);
    end
    checks++;
    if (req_seen != r0) begin errors++; $display("FAIL zero_noreq: got %0d requests expected 0", req_seen - r0); end
  endtask

  task automatic test_busy_start();
    int d0;
    src_ready = '1; sink_ready = 1'b1;
    start_job(6);
    checks++;
    if (err !== 2'b00) begin errors++; $display("FAIL busy_errclr: got %b expected 00", err); end
    tick(); tick();
    send_beats(3);
    d0 = done_seen;
    cnt_limit = CW'(2); start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (beat_cnt !== CW'(3) || busy !== 1'b1) begin
      errors++; $display("FAIL busy_ignore: got cnt %0d busy %b expected 3 1", beat_cnt, busy);
    end
    send_beats(3);
    checks++;
    if (beat_cnt !== CW'(6) || done_seen != d0) begin
      errors++; $display("FAIL busy_cnt: got cnt %0d dones %0d expected 6 0", beat_cnt, done_seen - d0);
    end
    sink_done = 1'b1;
    tick();
    sink_done = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL busy_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_clear();
    int d0;
    src_ready = '1; sink_ready = 1'b1;
    start_job(8);
    tick(); tick();
    send_beats(5);
    d0 = done_seen;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if ({src_req, sink_req, busy, done} !== '0 || beat_cnt !== '0 || err !== 2'b00) begin
      errors++; $display("FAIL clr_outs: got ctl %b cnt %0d err %b expected all 0",
                         {src_req, sink_req, busy, done}, beat_cnt, err);
    end
    out_valid = 1'b1; out_ready = 1'b1; sink_done = 1'b1;  // ignored in IDLE
    repeat (4) tick();
    out_valid = 1'b0; out_ready = 1'b0; sink_done = 1'b0;
    checks++;
    if (done_seen != d0 || beat_cnt !== '0) begin
      errors++; $display("FAIL clr_nodone: got dones %0d cnt %0d expected 0 0", done_seen - d0, beat_cnt);
    end
    start_job(8);
    tick();
    checks++;
    if (src_req !== all_src) begin errors++; $display("FAIL clr_req: got %b expected %b", src_req, all_src); end
    tick();
    send_beats(8);
    sink_done = 1'b1;
    tick();
    sink_done = 1'b0;
    checks++;
    if (done !== 1'b1 || beat_cnt !== CW'(8)) begin
      errors++; $display("FAIL clr_rejob: got done %b cnt %0d expected 1 8", done, beat_cnt);
    end
    tick();
  endtask

  // Randomized back-to-back jobs; expected timing follows from the job rules:
  // requests 1 cycle after readiness, done 2 cycles after the final beat if the sink already
  // finished, otherwise 1 cycle after sink_done.
  task automatic test_back_to_back();
    for (int j = 0; j < 6; j++) begin
      int lim = $urandom_range(1, 12);
      int dly = $urandom_range(0, 4);
      int mode = $urandom_range(0, 1);
      int k = $urandom_range(1, lim);
      int d2 = $urandom_range(1, 4);
      if (dly > 0) begin
        src_ready = NS'($urandom_range(0, 3)); sink_ready = 1'b0;
      end else begin
        src_ready = '1; sink_ready = 1'b1;
      end
      start_job(lim);
      repeat (dly) tick();
      src_ready = '1; sink_ready = 1'b1;
      tick();
      checks++;
      if (src_req !== all_src || sink_req !== 1'b1) begin
        errors++; $display("FAIL b2b_req%0d: got %b/%b expected %b/1", j, src_req, sink_req, all_src);
      end
      tick();
      for (int b = 1; b <= lim; b++) begin
        out_ready = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          out_valid = $urandom_range(0, 1) == 1;
          tick();
        end
        out_valid = 1'b1; out_ready = 1'b1;
        sink_done = (mode == 0) && (b == k);
        tick();
        out_valid = 1'b0; out_ready = 1'b0; sink_done = 1'b0;
        checks++;
        if (beat_cnt !== CW'(b)) begin
          errors++; $display("FAIL b2b_cnt%0d: got %0d expected %0d", j, beat_cnt, b);
        end
      end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL b2b_early%0d: got %b expected 0", j, done); end
      if (mode == 1) begin
        repeat (d2 - 1) tick();
        sink_done = 1'b1;
      end
      tick();
      sink_done = 1'b0;
      checks++;
      if (done !== 1'b1 || err !== 2'b00 || beat_cnt !== CW'(lim)) begin
        errors++; $display("FAIL b2b_done%0d: got done %b err %b cnt %0d expected 1 00 %0d",
                           j, done, err, beat_cnt, lim);
      end
      tick();  // IDLE: the next iteration starts here
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d: got %b expected 0", j, busy); end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    src_ready = '1; sink_ready = 1'b1;
    start_job(8);
    tick(); tick();
    send_beats(2);
`ifdef MULTI_DATAFLOW_SOBEL_MDC_JOB_TRACKER_WDOG_EN
    while (!done && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n < 15 || n > 17) begin errors++; $display("FAIL wdog_time: got %0d cycles expected 15..17", n); end
    checks++;
    if (err !== 2'b10 || beat_cnt !== CW'(2)) begin
      errors++; $display("FAIL wdog_err: got err %b cnt %0d expected 10 2", err, beat_cnt);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wdog_idle: got %b expected 0", busy); end
`else
    while (!done && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 40 || busy !== 1'b1 || err !== 2'b00) begin
      errors++; $display("FAIL stall_wait: got %0d cycles busy %b err %b expected 40 1 00", n, busy, err);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL stall_clear: got busy %b done %b expected 0 0", busy, done);
    end
`endif
  endtask

  initial begin
    all_src = '1;
    test_reset();
    test_nominal();
    test_ready_gating();
    test_early_sink_done();
    test_zero_limit();
    test_busy_start();
    test_clear();
    test_back_to_back();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
